// File: rtl/artec_dma_pkg.sv
// Shared DMA types: channel index, request word, command bundle.
// Sized by PKG_CH_NUM / PKG_REQ_WIDTH.
package artec_dma_pkg;
  localparam int PKG_CH_NUM    = 4;
  localparam int PKG_REQ_WIDTH = 8;

  typedef logic [$clog2(PKG_CH_NUM)-1:0] ch_idx_t;
  typedef logic [PKG_REQ_WIDTH-1:0]      req_t;

  typedef struct packed {
    ch_idx_t ch;
    req_t    data;
  } dma_cmd_t;
endpackage

// File: rtl/artec_dma_arb_rr_client_if.sv
// Command handshake toward the DMA engine.
// master: cmd_valid/cmd_ch/cmd_data out, cmd_ready in.
interface artec_dma_arb_rr_client_if;
  import artec_dma_pkg::*;

  logic    cmd_valid;
  ch_idx_t cmd_ch;
  req_t    cmd_data;
  logic    cmd_ready;

  modport master (
    output cmd_valid, cmd_ch, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/artec_dma_req_fifo.sv
// Per-channel sync FIFO: push/pop/clr in, head/full/empty out.
// head reads 0 when empty.
module artec_dma_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  // Extra MSB tells full from empty.
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr)
      mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/artec_dma_arb_rr_client.sv
// Requester side of the DMA RR arbiter: per-channel queues, grant pop,
// one-deep command register, flush clear pulse and error pulses.
module artec_dma_arb_rr_client
  import artec_dma_pkg::*;
#(
  parameter int CH_NUM    = PKG_CH_NUM,
  parameter int REQ_WIDTH = PKG_REQ_WIDTH,
  parameter int CH_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [CH_NUM-1:0]                   ch_valid_i,
  input  logic [CH_NUM-1:0][REQ_WIDTH-1:0]    ch_data_i,
  output logic [CH_NUM-1:0]                   ch_ready_o,
  output logic [CH_NUM-1:0][REQ_WIDTH-1:0]    arb_req_o,
  output logic                                arb_clear_o,
  input  logic [$clog2(CH_NUM)-1:0]           grant_i,
  input  logic                                grant_valid_i,
  artec_dma_arb_rr_client_if.master           cmd,
  output logic                                err_zero_o,
  output logic                                err_grant_o
);
  logic [CH_NUM-1:0] full;
  logic [CH_NUM-1:0] empty;
  logic [CH_NUM-1:0] push;
  logic [CH_NUM-1:0] pop;
  logic [CH_NUM-1:0] zero;

  logic     g_nonempty;
  req_t     g_head;
  logic     stall;
  logic     accept;
  logic     cmd_v;
  dma_cmd_t cmd_q;

  assign ch_ready_o = ~full;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    assign zero[c] = ch_data_i[c] == '0;
    assign push[c] = ch_valid_i[c] && !full[c] &&
                     !zero[c] && !flush_i;
    assign pop[c]  = accept && (32'(grant_i) == c);

    artec_dma_req_fifo #(
      .DW    (REQ_WIDTH),
      .DEPTH (CH_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush_i),
      .push  (push[c]),
      .din   (ch_data_i[c]),
      .pop   (pop[c]),
      .head  (arb_req_o[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  // Loop select keeps out-of-range grants as "empty".
  always_comb begin
    g_nonempty = 1'b0;
    g_head     = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (32'(grant_i) == c && !empty[c]) begin
        g_nonempty = 1'b1;
        g_head     = arb_req_o[c];
      end
    end
  end

  assign stall  = cmd_v && !cmd.cmd_ready;
  assign accept = grant_valid_i && !flush_i &&
                  g_nonempty && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_v       <= 1'b0;
      cmd_q       <= '0;
      arb_clear_o <= 1'b0;
      err_zero_o  <= 1'b0;
      err_grant_o <= 1'b0;
    end else begin
      arb_clear_o <= flush_i;
      err_zero_o  <= !flush_i &&
                     |(ch_valid_i & ~full & zero);
      err_grant_o <= grant_valid_i && !flush_i && !accept;
      if (accept) begin
        cmd_v      <= 1'b1;
        cmd_q.ch   <= ch_idx_t'(grant_i);
        cmd_q.data <= g_head;
      end else if (cmd.cmd_ready) begin
        cmd_v <= 1'b0;
      end
    end
  end

  assign cmd.cmd_valid = cmd_v;
  assign cmd.cmd_ch    = cmd_q.ch;
  assign cmd.cmd_data  = cmd_q.data;
endmodule

// File: tb/tb_artec_dma_arb_rr_client.sv
// Self-checking bench for artec_dma_arb_rr_client (4 ch, 8 bit, depth 4).
// Directed scenarios plus randomized traffic against a queue model.
module tb_artec_dma_arb_rr_client;
  localparam int NC = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [3:0]      ch_valid;
  logic [3:0][7:0] ch_data;
  logic [3:0]      ch_ready;
  logic [3:0][7:0] arb_req;
  logic            arb_clear;
  logic [1:0]      grant;
  logic            gv;
  logic            cmd_ready;
  logic            err_zero;
  logic            err_grant;

  int n_tests = 0;
  int n_fail  = 0;

  artec_dma_arb_rr_client_if cmd_bus ();
  assign cmd_bus.cmd_ready = cmd_ready;

  artec_dma_arb_rr_client dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .ch_valid_i    (ch_valid),
    .ch_data_i     (ch_data),
    .ch_ready_o    (ch_ready),
    .arb_req_o     (arb_req),
    .arb_clear_o   (arb_clear),
    .grant_i       (grant),
    .grant_valid_i (gv),
    .cmd           (cmd_bus),
    .err_zero_o    (err_zero),
    .err_grant_o   (err_grant)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q [NC][$];
  bit         mv;
  logic [1:0] mch;
  logic [7:0] mdata;
  bit         mclr, mez, meg;

  function automatic logic [3:0][7:0] exp_req();
    logic [3:0][7:0] r;
    for (int c = 0; c < NC; c++)
      r[c] = (q[c].size() > 0) ? q[c][0] : 8'h00;
    return r;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    for (int c = 0; c < NC; c++)
      r[c] = q[c].size() < DEPTH;
    return r;
  endfunction

  task automatic model_edge();
    bit stall, acc;
    bit [3:0] do_push;
    if (rst) begin
      for (int c = 0; c < NC; c++) q[c].delete();
      mv = 0; mch = 0; mdata = 0;
      mclr = 0; mez = 0; meg = 0;
      return;
    end
    stall = mv && !cmd_ready;
    mclr = flush; mez = 0; meg = 0; acc = 0;
    do_push = '0;
    if (!flush) begin
      for (int c = 0; c < NC; c++)
        if (ch_valid[c] && q[c].size() < DEPTH) begin
          if (ch_data[c] == 8'h00) mez = 1;
          else do_push[c] = 1;
        end
      if (gv) begin
        if (q[grant].size() > 0 && !stall) acc = 1;
        else meg = 1;
      end
    end
    if (acc) begin
      mdata = q[grant].pop_front();
      mch = grant;
      mv = 1;
    end else if (cmd_ready) begin
      mv = 0;
    end
    for (int c = 0; c < NC; c++) begin
      if (flush) q[c].delete();
      else if (do_push[c]) q[c].push_back(ch_data[c]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; ch_valid = '0; ch_data = '0;
    grant = 0; gv = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); cmd_ready = 1;
    step(); step();
    n_tests++;
    if (arb_req !== 32'h0 || ch_ready !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_q: req=%h rdy=%h exp 0/F",
               arb_req, ch_ready);
    end
    n_tests++;
    if (cmd_bus.cmd_valid !== 1'b0 || cmd_bus.cmd_ch !== 2'd0 ||
        cmd_bus.cmd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_cmd: v=%b ch=%h d=%h exp 0/0/0",
               cmd_bus.cmd_valid, cmd_bus.cmd_ch,
               cmd_bus.cmd_data);
    end
    rst = 0;
    step();
    n_tests++;
    if (arb_clear !== 1'b0 || err_zero !== 1'b0 ||
        err_grant !== 1'b0 || arb_req !== 32'h0) begin
      n_fail++;
      $display("FAIL idle: clr=%b ez=%b eg=%b req=%h exp 0",
               arb_clear, err_zero, err_grant, arb_req);
    end
  endtask

  task automatic test_push_grant();
    ch_valid[2] = 1; ch_data[2] = 8'h11;
    step();
    idle_inputs();
    n_tests++;
    if (arb_req[2] !== 8'h11) begin
      n_fail++;
      $display("FAIL push_head: got %h exp 11", arb_req[2]);
    end
    grant = 2; gv = 1; cmd_ready = 1;
    step();
    idle_inputs();
    n_tests++;
    if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd_ch !== 2'd2 ||
        cmd_bus.cmd_data !== 8'h11 || arb_req[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL grant_cmd: v=%b ch=%h d=%h req2=%h exp 1/2/11/0",
               cmd_bus.cmd_valid, cmd_bus.cmd_ch,
               cmd_bus.cmd_data, arb_req[2]);
    end
    step();
    n_tests++;
    if (cmd_bus.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd_clear: v=%b exp 0", cmd_bus.cmd_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      ch_valid[1] = 1; ch_data[1] = 8'hA1 + 8'(i);
      step();
    end
    n_tests++;
    if (ch_ready[1] !== 1'b0 || ch_ready !== exp_ready()) begin
      n_fail++;
      $display("FAIL full_ready: got %h exp %h",
               ch_ready, exp_ready());
    end
    ch_data[1] = 8'hA5;
    step();
    idle_inputs();
    n_tests++;
    if (arb_req[1] !== 8'hA1 || ch_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL blocked_push: head=%h rdy=%b exp A1/0",
               arb_req[1], ch_ready[1]);
    end
    grant = 1; gv = 1; cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (cmd_bus.cmd_valid !== 1'b1 ||
          cmd_bus.cmd_data !== 8'hA1 + 8'(i)) begin
        n_fail++;
        $display("FAIL b2b_%0d: v=%b d=%h exp 1/%h", i,
                 cmd_bus.cmd_valid, cmd_bus.cmd_data,
                 8'hA1 + 8'(i));
      end
    end
    idle_inputs();
    step();
    n_tests++;
    if (arb_req[1] !== 8'h00 || ch_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_drain: head=%h rdy=%b exp 0/1",
               arb_req[1], ch_ready[1]);
    end
  endtask

  task automatic test_stall();
    ch_valid[0] = 1; ch_data[0] = 8'h33;
    step();
    ch_data[0] = 8'h77;
    step();
    idle_inputs();
    grant = 0; gv = 1; cmd_ready = 0;
    step();
    step();
    n_tests++;
    if (err_grant !== 1'b1 || arb_req[0] !== 8'h77 ||
        cmd_bus.cmd_valid !== 1'b1 ||
        cmd_bus.cmd_data !== 8'h33 || cmd_bus.cmd_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_grant: eg=%b head=%h v=%b d=%h exp 1/77/1/33",
               err_grant, arb_req[0], cmd_bus.cmd_valid,
               cmd_bus.cmd_data);
    end
    grant = 3;
    step();
    n_tests++;
    if (err_grant !== 1'b1 || cmd_bus.cmd_data !== 8'h33) begin
      n_fail++;
      $display("FAIL empty_grant: eg=%b d=%h exp 1/33",
               err_grant, cmd_bus.cmd_data);
    end
    cmd_ready = 1; grant = 0;
    step();
    idle_inputs();
    step();
    n_tests++;
    if (err_grant !== 1'b0 || cmd_bus.cmd_data !== 8'h77 ||
        arb_req[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL stall_recover: eg=%b d=%h head=%h exp 0/77/0",
               err_grant, cmd_bus.cmd_data, arb_req[0]);
    end
  endtask

  task automatic test_zero_same_cycle();
    ch_valid[0] = 1; ch_data[0] = 8'h00;
    step();
    idle_inputs();
    n_tests++;
    if (err_zero !== 1'b1 || arb_req[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_push: ez=%b head=%h exp 1/0",
               err_zero, arb_req[0]);
    end
    ch_valid[3] = 1; ch_data[3] = 8'h44;
    step();
    ch_data[3] = 8'h55; grant = 3; gv = 1;
    step();
    idle_inputs();
    n_tests++;
    if (cmd_bus.cmd_data !== 8'h44 || arb_req[3] !== 8'h55 ||
        err_zero !== 1'b0 || ch_ready[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL push_pop: d=%h head=%h ez=%b exp 44/55/0",
               cmd_bus.cmd_data, arb_req[3], err_zero);
    end
    grant = 3; gv = 1;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 4; i++) begin
      ch_valid = 4'hF;
      for (int c = 0; c < NC; c++)
        ch_data[c] = 8'($urandom_range(1, 255));
      step();
    end
    n_tests++;
    if (ch_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL fill_all: rdy=%h exp 0", ch_ready);
    end
    ch_valid = 4'hF; flush = 1; grant = 1; gv = 1;
    step();
    idle_inputs();
    n_tests++;
    if (arb_req !== 32'h0 || arb_clear !== 1'b1 ||
        ch_ready !== 4'hF || err_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: req=%h clr=%b rdy=%h eg=%b exp 0/1/F/0",
               arb_req, arb_clear, ch_ready, err_grant);
    end
    step();
    n_tests++;
    if (arb_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pulse: clr=%b exp 0", arb_clear);
    end
    ch_valid[2] = 1; ch_data[2] = 8'h99;
    step();
    idle_inputs();
    grant = 2; gv = 1; cmd_ready = 0;
    step();
    idle_inputs();
    rst = 1;
    step();
    rst = 0; cmd_ready = 1;
    n_tests++;
    if (cmd_bus.cmd_valid !== 1'b0 || arb_req !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: v=%b req=%h exp 0/0",
               cmd_bus.cmd_valid, arb_req);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < NC; c++) begin
        ch_valid[c] = ($urandom_range(0, 2) == 0);
        ch_data[c]  = ($urandom_range(0, 9) == 0) ?
                      8'h00 : 8'($urandom_range(1, 255));
      end
      grant     = 2'($urandom_range(0, 3));
      gv        = ($urandom_range(0, 1) == 1);
      cmd_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
      n_tests++;
      if (arb_req !== exp_req() || ch_ready !== exp_ready()) begin
        n_fail++;
        $display("FAIL rnd_q[%0d]: req=%h rdy=%h exp %h/%h", i,
                 arb_req, ch_ready, exp_req(), exp_ready());
      end
      n_tests++;
      if (cmd_bus.cmd_valid !== mv ||
          (mv && (cmd_bus.cmd_ch !== mch ||
                  cmd_bus.cmd_data !== mdata))) begin
        n_fail++;
        $display("FAIL rnd_cmd[%0d]: v=%b ch=%h d=%h exp %b/%h/%h",
                 i, cmd_bus.cmd_valid, cmd_bus.cmd_ch,
                 cmd_bus.cmd_data, mv, mch, mdata);
      end
      n_tests++;
      if (err_zero !== mez || err_grant !== meg ||
          arb_clear !== mclr) begin
        n_fail++;
        $display("FAIL rnd_flags[%0d]: ez=%b eg=%b clr=%b exp %b/%b/%b",
                 i, err_zero, err_grant, arb_clear, mez, meg, mclr);
      end
    end
    idle_inputs();
    cmd_ready = 1;
  endtask

  initial begin
    test_reset();
    test_push_grant();
    test_fill();
    test_stall();
    test_zero_same_cycle();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
